uart_tx_sched: RTL and testbench

Transmit scheduler that shares the single UART transmitter between `NUM_REQ` byte producers. It round-robin arbitrates requesters into a shared circular byte queue and presents the queue head to the transmitter through its `queue_not_empty`/`tx_data`/`tx_started` handshake. It also owns the 13-bit baud divisor register and applies divisor changes only between frames. It sits between the SPART register/bus logic and the transmitter.

---
 rtl/uart_pkg.sv | 6 +
 rtl/rr_arbiter.sv | 41 ++++
 rtl/uart_tx_sched.sv | 133 +++++++++++++
 tb/tb_uart_tx_sched.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: divisor width, reset divisor and scheduler states.
package uart_pkg;
  localparam int unsigned BAUD_W = 13;
  localparam logic [BAUD_W-1:0] DEFAULT_BAUD = 13'd434;
  typedef enum logic {RUN, HOLD} sched_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from a rotating priority pointer.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] gnt_idx;
  logic [PW-1:0] idx;
  logic          found;

  // First requester at or after the pointer, wrapping modulo N.
  always_comb begin
    grant   = '0;
    gnt_idx = ptr;
    idx     = ptr;
    found   = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = PW'((32'(ptr) + k) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        gnt_idx    = idx;
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + PW'(1);
    end
  end
endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter among NUM_REQ producers through a circular byte
// queue, and applies baud divisor writes only while the transmitter is idle.
module uart_tx_sched
  import uart_pkg::BAUD_W, uart_pkg::sched_state_t, uart_pkg::RUN, uart_pkg::HOLD;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DEPTH   = 8,
  parameter logic [BAUD_W-1:0] DEFAULT_BAUD = uart_pkg::DEFAULT_BAUD
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       flush,
  input  logic                       cfg_we,
  input  logic [BAUD_W-1:0]          cfg_baud,
  input  logic                       tx_ready,
  input  logic                       tx_started,
  output logic                       queue_not_empty,
  output logic [7:0]                 tx_data,
  output logic [BAUD_W-1:0]          baud,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       cfg_pending
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned OW = PW + 1;

  logic [7:0]         mem [DEPTH];
  logic [PW-1:0]      rd_ptr;
  logic [PW-1:0]      wr_ptr;
  logic [NUM_REQ-1:0] grant;
  logic               can_push;
  logic               push;
  logic               pop;
  logic [7:0]         push_data;
  logic [OW-1:0]      occ_nxt;
  logic [7:0]         data_nxt;
  logic [BAUD_W-1:0]  pending;
  sched_state_t       state;
  sched_state_t       state_nxt;

  // No pass-through: a full queue refuses even when a pop happens this cycle.
  assign can_push = (occupancy != OW'(DEPTH)) && !flush;
  assign req_ready = grant;
  assign push = |grant;
  assign pop  = tx_started && (occupancy != '0);

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid & {NUM_REQ{can_push}}),
    .advance (push),
    .grant   (grant)
  );

  always_comb begin
    push_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) push_data = req_data[8*i +: 8];
    end
  end

  // Next head byte, so tx_data can be registered alongside occupancy.
  always_comb begin
    occ_nxt = flush ? '0 : occupancy + OW'(push) - OW'(pop);
    if (occ_nxt == '0) begin
      data_nxt = '0;
    end else if (occupancy == '0) begin
      data_nxt = push_data;
    end else if (pop) begin
      data_nxt = (occupancy == OW'(1)) ? push_data : mem[rd_ptr + PW'(1)];
    end else begin
      data_nxt = tx_data;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (cfg_we)   state_nxt = HOLD;
      HOLD:    if (tx_ready) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      occupancy       <= '0;
      tx_data         <= '0;
      queue_not_empty <= 1'b0;
      state           <= RUN;
      baud            <= DEFAULT_BAUD;
      pending         <= DEFAULT_BAUD;
      cfg_pending     <= 1'b0;
    end else begin
      occupancy       <= occ_nxt;
      tx_data         <= data_nxt;
      state           <= state_nxt;
      queue_not_empty <= (state_nxt == RUN) && (occ_nxt != '0);
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
      // Divisor only moves when the transmitter is idle; last write wins.
      case (state)
        RUN: begin
          if (cfg_we) begin
            pending     <= cfg_baud;
            cfg_pending <= 1'b1;
          end
        end
        HOLD: begin
          if (cfg_we) pending <= cfg_baud;
          if (tx_ready) begin
            baud        <= cfg_we ? cfg_baud : pending;
            cfg_pending <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: directed scenarios plus randomized traffic against a queue model.
module tb_uart_tx_sched;
  localparam int NR    = 4;
  localparam int DEPTH = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [8*NR-1:0]   req_data;
  logic [NR-1:0]     req_ready;
  logic              flush;
  logic              cfg_we;
  logic [12:0]       cfg_baud;
  logic              tx_ready;
  logic              tx_started;
  logic              queue_not_empty;
  logic [7:0]        tx_data;
  logic [12:0]       baud;
  logic [3:0]        occupancy;
  logic              cfg_pending;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [7:0]  mq[$];
  int          rr;
  bit          m_hold;
  logic [12:0] m_baud;
  logic [12:0] m_pend;
  bit          m_cfgp;

  // Transmitter model state for the random phase
  bit start_next;
  int busy;

  uart_tx_sched #(.NUM_REQ(NR), .DEPTH(DEPTH), .DEFAULT_BAUD(13'd434)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_ready       (req_ready),
    .flush           (flush),
    .cfg_we          (cfg_we),
    .cfg_baud        (cfg_baud),
    .tx_ready        (tx_ready),
    .tx_started      (tx_started),
    .queue_not_empty (queue_not_empty),
    .tx_data         (tx_data),
    .baud            (baud),
    .occupancy       (occupancy),
    .cfg_pending     (cfg_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NR-1:0] model_grant();
    logic [NR-1:0] g;
    g = '0;
    if (mq.size() < DEPTH && !flush) begin
      for (int k = 0; k < NR; k++) begin
        if (req_valid[(rr + k) % NR]) begin
          g[(rr + k) % NR] = 1'b1;
          break;
        end
      end
    end
    return g;
  endfunction

  function automatic bit model_qne();
    return !m_hold && (mq.size() != 0);
  endfunction

  task automatic model_reset();
    mq.delete();
    rr = 0; m_hold = 0; m_baud = 13'd434; m_pend = 13'd434; m_cfgp = 0;
    start_next = 0; busy = 0;
  endtask

  // Inputs are set at a falling edge; check ready, advance model, cross one rising edge, check outputs.
  task automatic tick();
    logic [NR-1:0] g;
    #1;
    g = model_grant();
    chk("req_ready", 32'(req_ready), 32'(g));
    if (flush) begin
      mq.delete();
    end else begin
      if (tx_started && mq.size() != 0) void'(mq.pop_front());
      for (int i = 0; i < NR; i++) begin
        if (g[i]) begin
          mq.push_back(req_data[8*i +: 8]);
          rr = (i + 1) % NR;
        end
      end
    end
    if (!m_hold) begin
      if (cfg_we) begin m_pend = cfg_baud; m_cfgp = 1; m_hold = 1; end
    end else begin
      if (cfg_we) m_pend = cfg_baud;
      if (tx_ready) begin m_baud = m_pend; m_cfgp = 0; m_hold = 0; end
    end
    @(posedge clk);
    @(negedge clk);
    chk("occupancy", 32'(occupancy), 32'(mq.size()));
    chk("queue_not_empty", 32'(queue_not_empty), 32'(model_qne()));
    chk("tx_data", 32'(tx_data), (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
    chk("baud", 32'(baud), 32'(m_baud));
    chk("cfg_pending", 32'(cfg_pending), 32'(m_cfgp));
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_data = '0; flush = 0; cfg_we = 0; cfg_baud = '0;
    tx_ready = 0; tx_started = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  task automatic do_flush();
    idle_inputs();
    flush = 1;
    tick();
    flush = 0;
  endtask

  initial begin
    do_reset();
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_qne", 32'(queue_not_empty), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    chk("rst_baud", 32'(baud), 32'd434);
    chk("rst_cfg_pending", 32'(cfg_pending), 32'd0);
    #1 chk("rst_req_ready", 32'(req_ready), 32'd0);

    // Requesters 0 and 2 alternate
    req_valid = 4'b0101;
    req_data  = {8'h00, 8'hA2, 8'h00, 8'hA0};
    for (int i = 0; i < 4; i++) begin
      #1 chk("rr_grant", 32'(req_ready), (i % 2 == 0) ? 32'b0001 : 32'b0100);
      tick();
    end
    chk("rr_occ", 32'(occupancy), 32'd4);
    chk("rr_head0", 32'(tx_data), 32'hA0);
    req_valid = '0;
    tx_started = 1;
    tick();
    tx_started = 0;
    chk("rr_head1", 32'(tx_data), 32'hA2);
    chk("rr_occ_pop", 32'(occupancy), 32'd3);
    do_flush();

    // Fill to full, then pop with valid held
    req_valid = 4'b0010;
    for (int i = 0; i < DEPTH; i++) begin
      req_data = {8'h00, 8'h00, 8'(8'h10 + i), 8'h00};
      tick();
    end
    chk("full_occ", 32'(occupancy), 32'd8);
    req_data = {8'h00, 8'h00, 8'h99, 8'h00};
    #1 chk("full_ready", 32'(req_ready), 32'd0);
    tick();
    tx_started = 1;
    #1 chk("full_pop_ready", 32'(req_ready), 32'd0);
    tick();
    tx_started = 0;
    chk("full_after_pop", 32'(occupancy), 32'd7);
    #1 chk("refill_ready", 32'(req_ready), 32'b0010);
    tick();
    chk("refill_occ", 32'(occupancy), 32'd8);
    do_flush();

    // Single frame of 8'h55
    req_valid = 4'b0001; req_data = {24'h0, 8'h55};
    tick();
    req_valid = '0;
    chk("f55_qne", 32'(queue_not_empty), 32'd1);
    tx_ready = 1;
    tick();
    tx_ready = 0; tx_started = 1;
    chk("f55_data", 32'(tx_data), 32'h55);
    chk("f55_occ_t1", 32'(occupancy), 32'd1);
    tick();
    tx_started = 0;
    chk("f55_occ_t2", 32'(occupancy), 32'd0);
    chk("f55_data_t2", 32'(tx_data), 32'h0);

    // Divisor change mid-frame
    req_valid = 4'b1000; req_data = {8'h33, 24'h0};
    for (int i = 0; i < 3; i++) tick();
    req_valid = '0;
    cfg_we = 1; cfg_baud = 13'd27;
    tick();
    cfg_we = 0;
    chk("cfg_qne_hold", 32'(queue_not_empty), 32'd0);
    chk("cfg_baud_kept", 32'(baud), 32'd434);
    chk("cfg_pending_set", 32'(cfg_pending), 32'd1);
    tick(); tick();
    chk("cfg_baud_kept2", 32'(baud), 32'd434);
    tx_ready = 1;
    tick();
    tx_ready = 0;
    chk("cfg_baud_new", 32'(baud), 32'd27);
    chk("cfg_qne_resume", 32'(queue_not_empty), 32'd1);
    chk("cfg_pending_clr", 32'(cfg_pending), 32'd0);

    // Two writes in HOLD, last wins
    cfg_we = 1; cfg_baud = 13'd100;
    tick();
    cfg_baud = 13'd200;
    tick();
    cfg_we = 0;
    chk("cfg2_baud_kept", 32'(baud), 32'd27);
    tx_ready = 1;
    tick();
    tx_ready = 0;
    chk("cfg2_baud", 32'(baud), 32'd200);

    // Flush with 5 queued and a push offered
    req_valid = 4'b1000;
    tick(); tick();
    chk("fl_occ5", 32'(occupancy), 32'd5);
    req_valid = 4'b0001; req_data = {24'h0, 8'h77}; flush = 1;
    #1 chk("fl_ready", 32'(req_ready), 32'd0);
    tick();
    flush = 0; req_valid = '0;
    chk("fl_occ0", 32'(occupancy), 32'd0);
    tx_started = 1;
    tick();
    tx_started = 0;
    chk("fl_ignored_occ", 32'(occupancy), 32'd0);
    chk("fl_ignored_data", 32'(tx_data), 32'h0);

    // Randomized traffic with a simple transmitter model
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      req_valid = NR'($urandom);
      req_data  = $urandom;
      flush     = ($urandom_range(0, 31) == 0);
      cfg_we    = ($urandom_range(0, 19) == 0);
      cfg_baud  = 13'($urandom);
      tx_started = start_next || ($urandom_range(0, 49) == 0);
      start_next = 0;
      if (busy > 0) begin
        tx_ready = 0;
        busy--;
      end else begin
        tx_ready = 1;
      end
      if (tx_ready && model_qne()) begin
        start_next = 1;
        busy = $urandom_range(1, 12);
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
